// File: rtl/uart_pkg.sv
// Types and constants shared by the UART receive path (sampler and frame FSM).
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BIT   = 2'd2
   } t_rx_samp_state;

   localparam int UART_DATA_BITS = 8;
   localparam int UART_IDX_W     = 4;

   function automatic logic maj3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Baud divider: emits one tick every div+1 clocks; clr restarts the period.
module uart_tick_gen #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] div_cnt_q;
   logic [DIV_W-1:0] div_cnt_d;

   assign tick = (div_cnt_q == div);

   always_comb begin
      div_cnt_d = div_cnt_q + 1'b1;
      if (clr || tick) begin
         div_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive bit-timing front end: synchronise rx, qualify the start bit,
// majority-vote each bit around its centre and emit one strobe per frame bit.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int DIV_W       = 16,
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx_pin,
   input  logic                  enable,
   input  logic [DIV_W-1:0]      baud_div,
   input  logic                  parity_en,
   input  logic [1:0]            stop_bits,
   output logic                  bit_valid,
   output logic                  bit_data,
   output logic [UART_IDX_W-1:0] bit_idx,
   output logic                  frame_active,
   output logic                  start_glitch,
   output logic                  noise
);

   localparam int SUB_W = $clog2(OVERSAMPLE);
   localparam logic [SUB_W-1:0] POS_V1 = SUB_W'(OVERSAMPLE / 2 - 1);
   localparam logic [SUB_W-1:0] POS_V2 = SUB_W'(OVERSAMPLE / 2);
   localparam logic [SUB_W-1:0] POS_V3 = SUB_W'(OVERSAMPLE / 2 + 1);
   localparam logic [UART_IDX_W-1:0] LAST_BASE = UART_IDX_W'(UART_DATA_BITS + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   rx_s;
   logic                   rx_prev_q;
   logic                   start_edge;

   t_rx_samp_state         state_q, state_d;
   logic [SUB_W-1:0]       sub_cnt_q, sub_cnt_d;
   logic [DIV_W-1:0]       div_lat_q, div_lat_d;
   logic                   par_en_q, par_en_d;
   logic                   stop2_q, stop2_d;
   logic [UART_IDX_W-1:0]  idx_q, idx_d;
   logic [1:0]             vote_q, vote_d;
   logic                   start_pend_q, start_pend_d;

   logic                   bit_valid_q, bit_valid_d;
   logic                   bit_data_q, bit_data_d;
   logic [UART_IDX_W-1:0]  bit_idx_q, bit_idx_d;
   logic                   glitch_q, glitch_d;
   logic                   noise_q, noise_d;

   logic                   tick;
   logic                   tick_clr;
   logic [2:0]             votes;
   logic [UART_IDX_W-1:0]  frame_last;

   assign sync_d     = {sync_q[SYNC_STAGES-2:0], rx_pin};
   assign rx_s       = sync_q[SYNC_STAGES-1];
   assign start_edge = ~rx_s & rx_prev_q;
   assign votes      = {vote_q, rx_s};
   assign frame_last = LAST_BASE
                       + {{(UART_IDX_W-1){1'b0}}, par_en_q}
                       + {{(UART_IDX_W-1){1'b0}}, stop2_q};

   uart_tick_gen #(
      .DIV_W (DIV_W)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (tick_clr),
      .div   (div_lat_q),
      .tick  (tick)
   );

   always_comb begin
      state_d      = state_q;
      sub_cnt_d    = sub_cnt_q;
      div_lat_d    = div_lat_q;
      par_en_d     = par_en_q;
      stop2_d      = stop2_q;
      idx_d        = idx_q;
      vote_d       = vote_q;
      start_pend_d = 1'b0;
      bit_valid_d  = 1'b0;
      bit_data_d   = bit_data_q;
      bit_idx_d    = bit_idx_q;
      glitch_d     = 1'b0;
      noise_d      = 1'b0;
      tick_clr     = 1'b0;

      case (state_q)
         IDLE: begin
            // start_pend covers an edge that arrived during the final stop strobe
            if (enable && (start_edge || start_pend_q)) begin
               state_d   = START;
               div_lat_d = baud_div;
               par_en_d  = parity_en;
               stop2_d   = (stop_bits == 2'd2);
               sub_cnt_d = '0;
               idx_d     = '0;
               tick_clr  = 1'b1;
            end
         end

         START: begin
            if (tick) begin
               if (sub_cnt_q == POS_V1) begin
                  if (rx_s) begin
                     glitch_d = 1'b1;
                     state_d  = IDLE;
                  end else begin
                     // the qualifying sample doubles as the first vote of the start bit
                     state_d   = BIT;
                     vote_d    = {vote_q[0], rx_s};
                     sub_cnt_d = POS_V2;
                  end
               end else begin
                  sub_cnt_d = sub_cnt_q + 1'b1;
               end
            end
         end

         BIT: begin
            if (tick) begin
               sub_cnt_d = sub_cnt_q + 1'b1;
               if ((sub_cnt_q == POS_V1) || (sub_cnt_q == POS_V2)) begin
                  vote_d = {vote_q[0], rx_s};
               end
               if (sub_cnt_q == POS_V3) begin
                  bit_valid_d = 1'b1;
                  bit_data_d  = maj3(votes);
                  noise_d     = ~((&votes) | ~(|votes));
                  bit_idx_d   = idx_q;
                  idx_d       = idx_q + 1'b1;
               end
            end
            if (bit_valid_q && (bit_idx_q == frame_last)) begin
               state_d      = IDLE;
               start_pend_d = start_edge;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q       <= '1;
         rx_prev_q    <= 1'b1;
         state_q      <= IDLE;
         sub_cnt_q    <= '0;
         div_lat_q    <= '0;
         par_en_q     <= 1'b0;
         stop2_q      <= 1'b0;
         idx_q        <= '0;
         vote_q       <= '0;
         start_pend_q <= 1'b0;
         bit_valid_q  <= 1'b0;
         bit_data_q   <= 1'b1;
         bit_idx_q    <= '0;
         glitch_q     <= 1'b0;
         noise_q      <= 1'b0;
      end else begin
         sync_q       <= sync_d;
         rx_prev_q    <= rx_s;
         state_q      <= state_d;
         sub_cnt_q    <= sub_cnt_d;
         div_lat_q    <= div_lat_d;
         par_en_q     <= par_en_d;
         stop2_q      <= stop2_d;
         idx_q        <= idx_d;
         vote_q       <= vote_d;
         start_pend_q <= start_pend_d;
         bit_valid_q  <= bit_valid_d;
         bit_data_q   <= bit_data_d;
         bit_idx_q    <= bit_idx_d;
         glitch_q     <= glitch_d;
         noise_q      <= noise_d;
      end
   end

   assign bit_valid    = bit_valid_q;
   assign bit_data     = bit_data_q;
   assign bit_idx      = bit_idx_q;
   assign start_glitch = glitch_q;
   assign noise        = noise_q;
   assign frame_active = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: table of frames plus hand-built corner sequences.
module tb_uart_rx_sampler;

   localparam int DIV_W = 16;
   localparam int OS    = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             rx_pin;
   logic             enable;
   logic [DIV_W-1:0] baud_div;
   logic             parity_en;
   logic [1:0]       stop_bits;
   logic             bit_valid;
   logic             bit_data;
   logic [3:0]       bit_idx;
   logic             frame_active;
   logic             start_glitch;
   logic             noise;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_rx_sampler #(
      .DIV_W       (DIV_W),
      .OVERSAMPLE  (OS),
      .SYNC_STAGES (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_pin       (rx_pin),
      .enable       (enable),
      .baud_div     (baud_div),
      .parity_en    (parity_en),
      .stop_bits    (stop_bits),
      .bit_valid    (bit_valid),
      .bit_data     (bit_data),
      .bit_idx      (bit_idx),
      .frame_active (frame_active),
      .start_glitch (start_glitch),
      .noise        (noise)
   );

   // strobe recorder
   int       cyc = 0;
   int       n_str = 0;
   int       n_glitch = 0;
   logic     str_data  [256];
   logic     str_noise [256];
   logic [3:0] str_idx [256];
   int       str_cyc   [256];

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (bit_valid && n_str < 256) begin
         str_data[n_str]  <= bit_data;
         str_noise[n_str] <= noise;
         str_idx[n_str]   <= bit_idx;
         str_cyc[n_str]   <= cyc;
         n_str            <= n_str + 1;
      end
      if (start_glitch) n_glitch <= n_glitch + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx_pin = 1'b1;
      hold(n);
   endtask

   // gbit selects a frame bit that gets a 5-clk inverted pulse around its centre vote
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop2,
                             input int bclk, input int gbit);
      logic [11:0] line;
      int nb;
      line = '1;
      line[0] = 1'b0;
      for (int i = 0; i < 8; i++) line[1+i] = d[i];
      nb = 9;
      if (par) begin line[nb] = ^d; nb++; end
      line[nb] = 1'b1; nb++;
      if (stop2) begin line[nb] = 1'b1; nb++; end
      for (int b = 0; b < nb; b++) begin
         rx_pin = line[b];
         if (b == gbit) begin
            hold(43);
            rx_pin = ~line[b];
            hold(5);
            rx_pin = line[b];
            hold(bclk - 48);
         end else begin
            hold(bclk);
         end
      end
   endtask

   task automatic check_frame(input string tag, input int base, input int n,
                              input logic [11:0] exp_bits, input logic [11:0] exp_noise,
                              input int period);
      logic [11:0] gb, gn;
      int idx_err, sp_err;
      gb = '0; gn = '0; idx_err = 0; sp_err = 0;
      for (int i = 0; i < n && i < 12; i++) begin
         gb[i] = str_data[base+i];
         gn[i] = str_noise[base+i];
         if (str_idx[base+i] !== 4'(i)) idx_err++;
         if (i > 0 && (str_cyc[base+i] - str_cyc[base+i-1]) != period) sp_err++;
      end
      check({tag, " bits"}, 32'(gb), 32'(exp_bits));
      check({tag, " noise"}, 32'(gn), 32'(exp_noise));
      check({tag, " idx_errs"}, 32'(idx_err), 32'd0);
      check({tag, " spacing_errs"}, 32'(sp_err), 32'd0);
   endtask

   typedef struct {
      logic [7:0]  d;
      logic        par;
      logic [1:0]  stops;
      logic [15:0] bd;
      int          n;
      logic [11:0] bits;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int base;
      int g0;

      vecs[0] = '{d: 8'h55, par: 1'b0, stops: 2'd1, bd: 16'd4, n: 10, bits: 12'h2AA};
      vecs[1] = '{d: 8'hA3, par: 1'b1, stops: 2'd2, bd: 16'd4, n: 12, bits: 12'hD46};
      vecs[2] = '{d: 8'h00, par: 1'b0, stops: 2'd0, bd: 16'd0, n: 10, bits: 12'h200};
      vecs[3] = '{d: 8'h0F, par: 1'b1, stops: 2'd3, bd: 16'd1, n: 11, bits: 12'h41E};
      vecs[4] = '{d: 8'hFF, par: 1'b0, stops: 2'd2, bd: 16'd2, n: 11, bits: 12'h7FE};

      rst_n = 1'b0; rx_pin = 1'b1; enable = 1'b1; baud_div = 16'd4;
      parity_en = 1'b0; stop_bits = 2'd1;
      hold(5);
      check("rst bit_valid", 32'(bit_valid), 32'd0);
      check("rst bit_data", 32'(bit_data), 32'd1);
      check("rst bit_idx", 32'(bit_idx), 32'd0);
      check("rst frame_active", 32'(frame_active), 32'd0);
      check("rst start_glitch", 32'(start_glitch), 32'd0);
      check("rst noise", 32'(noise), 32'd0);
      rst_n = 1'b1;
      idle(20);

      for (int v = 0; v < 5; v++) begin
         baud_div = vecs[v].bd; parity_en = vecs[v].par; stop_bits = vecs[v].stops;
         idle(20);
         base = n_str;
         send_frame(vecs[v].d, vecs[v].par, vecs[v].stops == 2'd2,
                    OS * (int'(vecs[v].bd) + 1), -1);
         idle(40);
         check($sformatf("vec%0d count", v), 32'(n_str - base), 32'(vecs[v].n));
         check_frame($sformatf("vec%0d", v), base, vecs[v].n, vecs[v].bits, 12'h000,
                     OS * (int'(vecs[v].bd) + 1));
         check($sformatf("vec%0d active_end", v), 32'(frame_active), 32'd0);
      end

      // start bit shorter than half a bit
      baud_div = 16'd4; parity_en = 1'b0; stop_bits = 2'd1;
      base = n_str; g0 = n_glitch;
      rx_pin = 1'b0;
      hold(15);
      idle(200);
      check("glitch pulses", 32'(n_glitch - g0), 32'd1);
      check("glitch strobes", 32'(n_str - base), 32'd0);
      check("glitch active", 32'(frame_active), 32'd0);

      // inverted pulse on the centre vote of data bit 3
      base = n_str;
      send_frame(8'h55, 1'b0, 1'b0, 80, 4);
      idle(40);
      check("noise count", 32'(n_str - base), 32'd10);
      check_frame("noise", base, 10, 12'h2AA, 12'h010, 80);

      // back-to-back frames at one tick per clock
      baud_div = 16'd0;
      idle(20);
      base = n_str;
      send_frame(8'h00, 1'b0, 1'b0, 16, -1);
      send_frame(8'hFF, 1'b0, 1'b0, 16, -1);
      idle(40);
      check("b2b count", 32'(n_str - base), 32'd20);
      check_frame("b2b f1", base, 10, 12'h200, 12'h000, 16);
      check_frame("b2b f2", base + 10, 10, 12'h3FE, 12'h000, 16);
      check("b2b gap", 32'(str_cyc[base+10] - str_cyc[base+9]), 32'd16);

      // enable dropped and baud_div changed mid-frame
      baud_div = 16'd4;
      idle(20);
      base = n_str;
      fork
         send_frame(8'h3C, 1'b0, 1'b0, 80, -1);
         begin
            hold(200);
            enable = 1'b0;
            baud_div = 16'd7;
         end
      join
      idle(40);
      check("en_off count", 32'(n_str - base), 32'd10);
      check_frame("en_off", base, 10, 12'h278, 12'h000, 80);
      base = n_str;
      send_frame(8'h55, 1'b0, 1'b0, 80, -1);
      idle(40);
      check("disabled strobes", 32'(n_str - base), 32'd0);
      check("disabled active", 32'(frame_active), 32'd0);
      enable = 1'b1; baud_div = 16'd4;
      idle(20);

      // reset in the middle of frame bit 5
      base = n_str;
      rx_pin = 1'b0; hold(80);
      for (int b = 0; b < 4; b++) begin rx_pin = b[0] ? 1'b0 : 1'b1; hold(80); end
      rx_pin = 1'b1; hold(40);
      check("midrst strobes", 32'(n_str - base), 32'd5);
      check("midrst active", 32'(frame_active), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst bit_valid", 32'(bit_valid), 32'd0);
      check("midrst frame_active", 32'(frame_active), 32'd0);
      check("midrst bit_data", 32'(bit_data), 32'd1);
      check("midrst bit_idx", 32'(bit_idx), 32'd0);
      check("midrst noise", 32'(noise), 32'd0);
      rx_pin = 1'b1;
      hold(10);
      rst_n = 1'b1;
      idle(100);
      check("midrst no_partial", 32'(n_str - base), 32'd5);
      base = n_str;
      send_frame(8'hA3, 1'b0, 1'b0, 80, -1);
      idle(40);
      check("after_rst count", 32'(n_str - base), 32'd10);
      check_frame("after_rst", base, 10, 12'h346, 12'h000, 80);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
